// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding, client ids and width defaults for the SDRAM port arbiter
package sdram_arb_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_CMD  = 2'd2,
    RD_DATA = 2'd3
  } state_e;
  localparam logic CLIENT_A = 1'b0;
  localparam logic CLIENT_V = 1'b1;
  localparam int ADDR_W_DEF = 22;
  localparam int DATA_W_DEF = 16;
endpackage

// File: rtl/sdram_arb_grant.sv
// sdram_arb_grant: A-priority grant decision with a burst counter that lets V in after MAX_A_BURST A grants
module sdram_arb_grant
  import sdram_arb_pkg::*;
#(
  parameter int MAX_A_BURST = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pend_a_i,
  input  logic pend_v_i,
  input  logic arb_i,
  output logic gnt_id_o,
  output logic gnt_vld_o
);
  logic [3:0] cnt_q, cnt_d;
  logic       at_max;
  assign at_max    = cnt_q == 4'(MAX_A_BURST);
  assign gnt_vld_o = pend_a_i | pend_v_i;
  assign gnt_id_o  = (pend_v_i && (!pend_a_i || at_max)) ? CLIENT_V : CLIENT_A;
  // only A grants made while V waits advance the count; anything else restarts it
  always_comb
    cnt_d = (!arb_i || !gnt_vld_o)                 ? cnt_q :
            (gnt_id_o == CLIENT_V || !pend_v_i)    ? 4'd0  :
            at_max                                 ? cnt_q : cnt_q + 4'd1;
  always_ff @(posedge clk_i)
    cnt_q <= rst_i ? 4'd0 : cnt_d;
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: serialises audio (A) and visualizer (V) transactions onto one SDRAM master port
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MAX_A_BURST = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_waitrq,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_valid,
  input  logic [ADDR_W-1:0] v_addr,
  input  logic              v_read,
  input  logic              v_write,
  input  logic [DATA_W-1:0] v_wdata,
  output logic              v_waitrq,
  output logic [DATA_W-1:0] v_rdata,
  output logic              v_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_read,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_data_out,
  input  logic              ram_waitrq,
  input  logic              ram_valid,
  output logic              owner,
  output logic              busy
);
  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              rd_q, wr_q, owner_q;
  logic              gnt_id, gnt_vld, gnt_wr, done, rd_phase;
  sdram_arb_grant #(.MAX_A_BURST(MAX_A_BURST)) u_grant (
    .clk_i    (CLOCK_50),
    .rst_i    (reset),
    .pend_a_i (a_read | a_write),
    .pend_v_i (v_read | v_write),
    .arb_i    (state_q == IDLE),
    .gnt_id_o (gnt_id),
    .gnt_vld_o(gnt_vld)
  );
  // write wins when a client raises both read and write
  assign gnt_wr = (gnt_id == CLIENT_V) ? v_write : a_write;
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      owner_q <= CLIENT_A;
    end else begin
      case (state_q)
        IDLE: if (gnt_vld) begin
          state_q <= gnt_wr ? WR : RD_CMD;
          wr_q    <= gnt_wr;
          rd_q    <= !gnt_wr;
          addr_q  <= (gnt_id == CLIENT_V) ? v_addr : a_addr;
          data_q  <= (gnt_id == CLIENT_V) ? v_wdata : a_wdata;
          owner_q <= gnt_id;
        end
        WR: if (!ram_waitrq) begin
          state_q <= IDLE;
          wr_q    <= 1'b0;
        end
        RD_CMD: if (!ram_waitrq) begin
          state_q <= ram_valid ? IDLE : RD_DATA;
          rd_q    <= 1'b0;
        end
        default: if (ram_valid) state_q <= IDLE;
      endcase
    end
  end
  assign rd_phase = (state_q == RD_CMD) || (state_q == RD_DATA);
  assign done = ((state_q == WR) && !ram_waitrq) ||
                ((state_q == RD_CMD) && !ram_waitrq && ram_valid) ||
                ((state_q == RD_DATA) && ram_valid);
  assign a_waitrq    = !(done && owner_q == CLIENT_A);
  assign v_waitrq    = !(done && owner_q == CLIENT_V);
  assign a_valid     = ram_valid && rd_phase && owner_q == CLIENT_A;
  assign v_valid     = ram_valid && rd_phase && owner_q == CLIENT_V;
  assign a_rdata     = ram_data_out;
  assign v_rdata     = ram_data_out;
  assign ram_addr    = addr_q;
  assign ram_data_in = data_q;
  assign ram_read    = rd_q;
  assign ram_write   = wr_q;
  assign owner       = owner_q;
  assign busy        = state_q != IDLE;
endmodule
